bldc_pwm_commutator: RTL and testbench

- Stage directly downstream of the CLK/3 divider in the BLDC controller.
- Consumes the divider's CLK_OUT as a one-in-three PWM tick enable and generates the PWM carrier.
- Decodes filtered hall sensors into a six-step commutation pattern.
- Drives six dead-time-protected gate signals (3 high-side, 3 low-side) to the inverter.

---
 rtl/bldc_pwm_commutator.sv | 173 +++++++++++++++++
 tb/tb_bldc_pwm_commutator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_pwm_commutator.sv
// rtl/bldc_pwm_commutator.sv - BLDC PWM carrier, hall filter and six-step dead-time commutator
module bldc_pwm_commutator #(
    parameter int PWM_BITS    = 8,
    parameter int DEAD_CYC    = 4,
    parameter int HALL_STABLE = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                TICK,
    input  logic [PWM_BITS-1:0] DUTY,
    input  logic [2:0]          HALL,
    input  logic                DIR,
    input  logic                EN,
    output logic [2:0]          GATE_H,
    output logic [2:0]          GATE_L,
    output logic                FAULT,
    output logic                PWM_WRAP
);

    typedef enum logic [1:0] {PH_OFF, PH_HI, PH_LO, PH_DEAD} phase_t;

    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYC - 1);
    localparam logic [3:0] STABLE    = 4'(HALL_STABLE);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty_l;
    logic                pwm_on;

    // Duty is latched only at wrap so a period never sees a mid-cycle change.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt      <= '0;
            duty_l   <= '0;
            PWM_WRAP <= 1'b0;
        end else begin
            PWM_WRAP <= 1'b0;
            if (TICK) begin
                if (cnt == '1) begin
                    cnt      <= '0;
                    duty_l   <= DUTY;
                    PWM_WRAP <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign pwm_on = (cnt < duty_l);

    logic [2:0] hall_s1;
    logic [2:0] hall_s2;
    logic [2:0] hall_last;
    logic [2:0] hall_acc;
    logic       hall_ok;
    logic [3:0] filt_cnt;
    logic [3:0] filt_next;
    logic       hall_valid;

    always_comb begin
        filt_next = (hall_s2 == hall_last) ? filt_cnt + 4'd1 : 4'd1;
    end

    assign hall_valid = (hall_acc != 3'b000) && (hall_acc != 3'b111);

    always_ff @(posedge CLK) begin
        if (RST) begin
            hall_s1   <= 3'b000;
            hall_s2   <= 3'b000;
            hall_last <= 3'b000;
            hall_acc  <= 3'b000;
            hall_ok   <= 1'b0;
            filt_cnt  <= 4'd0;
            FAULT     <= 1'b0;
        end else begin
            hall_s1   <= HALL;
            hall_s2   <= hall_s1;
            hall_last <= hall_s2;
            if (hall_s2 == hall_acc) begin
                filt_cnt <= 4'd0;
            end else if (filt_next >= STABLE) begin
                hall_acc <= hall_s2;
                hall_ok  <= 1'b1;
                filt_cnt <= 4'd0;
            end else begin
                filt_cnt <= filt_next;
            end
            if (hall_ok && !hall_valid) begin
                FAULT <= 1'b1;
            end else if (!EN && hall_ok) begin
                FAULT <= 1'b0;
            end
        end
    end

    logic [2:0] hi_mask;
    logic [2:0] lo_mask;
    logic [2:0] drv_hi;
    logic [2:0] drv_lo;

    // Six-step table in forward order; reverse simply swaps the roles.
    always_comb begin
        hi_mask = 3'b000;
        lo_mask = 3'b000;
        case (hall_acc)
            3'b101: begin hi_mask = 3'b100; lo_mask = 3'b010; end
            3'b100: begin hi_mask = 3'b100; lo_mask = 3'b001; end
            3'b110: begin hi_mask = 3'b010; lo_mask = 3'b001; end
            3'b010: begin hi_mask = 3'b010; lo_mask = 3'b100; end
            3'b011: begin hi_mask = 3'b001; lo_mask = 3'b100; end
            3'b001: begin hi_mask = 3'b001; lo_mask = 3'b010; end
            default: ;
        endcase
        drv_hi = DIR ? lo_mask : hi_mask;
        drv_lo = DIR ? hi_mask : lo_mask;
        if (!EN || FAULT || !hall_ok) begin
            drv_hi = 3'b000;
            drv_lo = 3'b000;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_phase
        phase_t     state;
        phase_t     req;
        logic [3:0] dead_cnt;
        logic       gate_h_q;
        logic       gate_l_q;

        always_comb begin
            req = drv_hi[i] ? PH_HI : (drv_lo[i] ? PH_LO : PH_OFF);
        end

        // Gates follow the state one cycle later, so DEAD always yields DEAD_CYC all-off cycles.
        always_ff @(posedge CLK) begin
            if (RST) begin
                state    <= PH_OFF;
                dead_cnt <= 4'd0;
                gate_h_q <= 1'b0;
                gate_l_q <= 1'b0;
            end else begin
                gate_h_q <= (state == PH_HI) && pwm_on;
                gate_l_q <= (state == PH_LO);
                case (state)
                    PH_OFF: state <= req;
                    PH_HI: begin
                        if (req != PH_HI) begin
                            state    <= PH_DEAD;
                            dead_cnt <= DEAD_LOAD;
                        end
                    end
                    PH_LO: begin
                        if (req != PH_LO) begin
                            state    <= PH_DEAD;
                            dead_cnt <= DEAD_LOAD;
                        end
                    end
                    PH_DEAD: begin
                        if (dead_cnt == 4'd0) begin
                            state <= req;
                        end else begin
                            dead_cnt <= dead_cnt - 4'd1;
                        end
                    end
                    default: state <= PH_OFF;
                endcase
            end
        end

        assign GATE_H[i] = gate_h_q;
        assign GATE_L[i] = gate_l_q;
    end

endmodule

// File: tb/tb_bldc_pwm_commutator.sv
// tb/tb_bldc_pwm_commutator.sv - directed table-driven bench for bldc_pwm_commutator
module tb_bldc_pwm_commutator;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TICK = 1'b0;
    logic [7:0] DUTY = 8'd0;
    logic [2:0] HALL = 3'b000;
    logic       DIR = 1'b0;
    logic       EN = 1'b0;
    logic [2:0] GATE_H;
    logic [2:0] GATE_L;
    logic       FAULT;
    logic       PWM_WRAP;

    int checks = 0;
    int errors = 0;
    int overlap = 0;
    int tick_ph = 0;

    typedef struct {
        logic       dir;
        logic [2:0] hall;
        logic [2:0] exp_h;
        logic [2:0] exp_l;
    } vec_t;

    vec_t       vecs[12];
    logic [2:0] gl[6];
    logic [2:0] gh[6];

    bldc_pwm_commutator #(
        .PWM_BITS(8),
        .DEAD_CYC(4),
        .HALL_STABLE(3)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .TICK(TICK),
        .DUTY(DUTY),
        .HALL(HALL),
        .DIR(DIR),
        .EN(EN),
        .GATE_H(GATE_H),
        .GATE_L(GATE_L),
        .FAULT(FAULT),
        .PWM_WRAP(PWM_WRAP)
    );

    always #5 CLK = ~CLK;

    initial begin
        forever begin
            @(negedge CLK);
            TICK = (tick_ph == 0);
            tick_ph = (tick_ph == 2) ? 0 : tick_ph + 1;
        end
    end

    always @(negedge CLK) begin
        if ((GATE_H & GATE_L) != 3'b000) overlap++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_wrap();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!PWM_WRAP && n < 1000);
        if (!PWM_WRAP) check("wrap_timeout", 0, 1);
    endtask

    task automatic measure(input int chg_at, input logic [7:0] new_duty,
                           output int per, output int hi);
        per = 0;
        hi  = 0;
        do begin
            hi += int'(GATE_H[2]);
            if (per == chg_at) DUTY = new_duty;
            @(negedge CLK);
            per++;
        end while (!PWM_WRAP && per < 2000);
    endtask

    task automatic hi_seen(input int n, output logic [2:0] m);
        m = 3'b000;
        repeat (n) begin
            @(negedge CLK);
            m |= GATE_H;
        end
    endtask

    initial begin
        int         per;
        int         hi;
        int         n;
        int         dev;
        logic [2:0] m;

        vecs[0]  = '{1'b0, 3'b101, 3'b100, 3'b010};
        vecs[1]  = '{1'b0, 3'b100, 3'b100, 3'b001};
        vecs[2]  = '{1'b0, 3'b110, 3'b010, 3'b001};
        vecs[3]  = '{1'b0, 3'b010, 3'b010, 3'b100};
        vecs[4]  = '{1'b0, 3'b011, 3'b001, 3'b100};
        vecs[5]  = '{1'b0, 3'b001, 3'b001, 3'b010};
        vecs[6]  = '{1'b1, 3'b101, 3'b010, 3'b100};
        vecs[7]  = '{1'b1, 3'b100, 3'b001, 3'b100};
        vecs[8]  = '{1'b1, 3'b110, 3'b001, 3'b010};
        vecs[9]  = '{1'b1, 3'b010, 3'b100, 3'b010};
        vecs[10] = '{1'b1, 3'b011, 3'b100, 3'b001};
        vecs[11] = '{1'b1, 3'b001, 3'b010, 3'b001};

        RST = 1'b1; EN = 1'b1; DIR = 1'b0; HALL = 3'b101; DUTY = 8'd64;
        idle(5);
        check("reset_gate_h", GATE_H, 0);
        check("reset_gate_l", GATE_L, 0);
        check("reset_fault", FAULT, 0);
        check("reset_wrap", PWM_WRAP, 0);
        RST = 1'b0;

        wait_wrap();
        measure(-1, 8'd0, per, hi);
        check("wrap_period", per, 768);
        check("duty64_on", hi, 192);
        check("gate_l_steady", GATE_L, 3'b010);

        measure(100, 8'd200, per, hi);
        check("duty_hold_64", hi, 192);
        check("wrap_period2", per, 768);
        measure(-1, 8'd0, per, hi);
        check("duty200_on", hi, 600);
        DUTY = 8'd255;

        HALL = 3'b100;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (GATE_L == 3'b010 && n < 20);
        check("hall_latency", n, 7);
        check("step_gate_l", GATE_L, 3'b001);
        idle(20);
        HALL = 3'b101;
        idle(20);
        check("back_101_gate_l", GATE_L, 3'b010);

        HALL = 3'b100;
        idle(2);
        HALL = 3'b101;
        dev = 0;
        repeat (20) begin
            @(negedge CLK);
            if (GATE_L != 3'b010) dev++;
        end
        check("glitch_rejected", dev, 0);

        HALL = 3'b111;
        idle(15);
        check("fault_set", FAULT, 1);
        idle(10);
        check("fault_gate_h", GATE_H, 0);
        check("fault_gate_l", GATE_L, 0);
        HALL = 3'b101;
        idle(20);
        check("fault_sticky", FAULT, 1);
        check("fault_sticky_gate_l", GATE_L, 0);
        EN = 1'b0;
        idle(1);
        EN = 1'b1;
        idle(20);
        check("fault_cleared", FAULT, 0);
        check("resume_gate_l", GATE_L, 3'b010);

        wait_wrap();
        HALL = 3'b110;
        idle(25);
        check("dir0_gate_l", GATE_L, 3'b001);
        hi_seen(10, m);
        check("dir0_gate_h", m, 3'b010);
        DIR = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            gl[k] = GATE_L;
            gh[k] = GATE_H;
        end
        check("dir_pre_gate_l", gl[0], 3'b001);
        dev = 0;
        for (int k = 1; k < 5; k++) begin
            if ((gl[k] | gh[k]) != 3'b000) dev++;
        end
        check("dir_dead_cycles", dev, 0);
        check("dir_post_gate_l", gl[5], 3'b010);
        hi_seen(10, m);
        check("dir1_gate_h", m, 3'b001);

        idle(10);
        DIR = 1'b0;
        idle(2);
        check("dead_before_rst", GATE_H | GATE_L, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_dead_gate_h", GATE_H, 0);
        check("rst_dead_gate_l", GATE_L, 0);
        check("rst_dead_fault", FAULT, 0);
        check("rst_dead_wrap", PWM_WRAP, 0);
        idle(1);
        RST = 1'b0;
        idle(20);
        check("rst_recover_gate_l", GATE_L, 3'b001);

        wait_wrap();
        for (int i = 0; i < 12; i++) begin
            DIR  = vecs[i].dir;
            HALL = vecs[i].hall;
            idle(25);
            check($sformatf("tbl%0d_gate_l", i), GATE_L, vecs[i].exp_l);
            hi_seen(10, m);
            check($sformatf("tbl%0d_gate_h", i), m, vecs[i].exp_h);
            check($sformatf("tbl%0d_fault", i), FAULT, 0);
        end

        check("no_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
